// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the hazard scoreboard.
//   - FROM_RF / FROM_E / FROM_M / FROM_W forwarding select codes
//   - EPC_ADDR_DEFAULT: CP0 register number of EPC
//   - fwd_pick(): fixed E > M > W priority encoder for forward selects
package hazard_pkg;

  localparam logic [1:0] FROM_RF = 2'd0;
  localparam logic [1:0] FROM_E  = 2'd1;
  localparam logic [1:0] FROM_M  = 2'd2;
  localparam logic [1:0] FROM_W  = 2'd3;

  localparam int EPC_ADDR_DEFAULT = 14;

  // Picks the youngest eligible producer; callers pass 1'b0 for stages
  // that a given consumer cannot see.
  function automatic logic [1:0] fwd_pick(input logic e_hit,
                                          input logic m_hit,
                                          input logic w_hit);
    logic [1:0] sel;
    sel = FROM_RF;
    if (e_hit)      sel = FROM_E;
    else if (m_hit) sel = FROM_M;
    else if (w_hit) sel = FROM_W;
    return sel;
  endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// mdu_busy_timer: MDU latency countdown.
//   clk, rst_n     clock / asynchronous active-low reset
//   start, is_div  MDU operation issued from E (div selects DIV_LAT)
//   flush          cancels a start in the same cycle
//   busy           countdown non-zero (high LAT cycles after a start)
//   start_ok       start accepted this cycle (start & ~flush)
module mdu_busy_timer #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  input  logic flush,
  output logic busy,
  output logic start_ok
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt_reg;

  assign start_ok = start & ~flush;
  assign busy     = (cnt_reg != '0);

  // A start reloads even when busy; the stall logic should have kept
  // D from issuing one, so that case is only flagged in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (start_ok) begin
      cnt_reg <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && start_ok) begin
      assert (cnt_reg == '0) else $error("mdu_busy_timer: start while busy");
    end
  end
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding selects and D-stage stall for the 5-stage
// pipeline, with internal MDU busy timing.
//   Inputs : clk, rst_n (async active-low), flush, Tuse/Tnew, stage
//            register addresses, RFWr enables, D-stage class bits,
//            mtc0 flags, MDU start.
//   Outputs: Stall (combinational), E_bubble (registered Stall),
//            MDU_busy, five 2-bit forward selects.
// Optional: define HAZARD_PERF_CNT_EN to add saturating stall-cause
//           counters perf_stall_data / perf_stall_mdu / perf_stall_eret.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int TNEW_W   = 2,
  parameter int MUL_LAT  = 5,
  parameter int DIV_LAT  = 10,
  parameter int EPC_ADDR = EPC_ADDR_DEFAULT,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [TNEW_W-1:0] T_use_RS,
  input  logic [TNEW_W-1:0] T_use_RT,
  input  logic [TNEW_W-1:0] E_Tnew,
  input  logic [TNEW_W-1:0] M_Tnew,
  input  logic [REG_AW-1:0] D_A1,
  input  logic [REG_AW-1:0] D_A2,
  input  logic [REG_AW-1:0] E_A1,
  input  logic [REG_AW-1:0] E_A2,
  input  logic [REG_AW-1:0] E_A3,
  input  logic [REG_AW-1:0] M_A2,
  input  logic [REG_AW-1:0] M_A3,
  input  logic [REG_AW-1:0] W_A3,
  input  logic              E_RFWr,
  input  logic              M_RFWr,
  input  logic              W_RFWr,
  input  logic              D_MDU_related,
  input  logic              D_eret,
  input  logic              E_MTC0,
  input  logic              M_MTC0,
  input  logic              E_MDU_start,
  input  logic              E_MDU_is_div,
  output logic              Stall,
  output logic              E_bubble,
  output logic              MDU_busy,
  output logic [1:0]        Fwd_D_RS_Sel,
  output logic [1:0]        Fwd_D_RT_Sel,
  output logic [1:0]        Fwd_E_A_Sel,
  output logic [1:0]        Fwd_E_B_Sel,
  output logic [1:0]        Fwd_M_WD_Sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_data,
  output logic [CNT_W-1:0]  perf_stall_mdu,
  output logic [CNT_W-1:0]  perf_stall_eret
`endif
);

  // A producer can forward only once its value exists (Tnew == 0);
  // W always holds a finished value.
  logic e_fwd_ok, m_fwd_ok;
  assign e_fwd_ok = E_RFWr && (E_Tnew == '0);
  assign m_fwd_ok = M_RFWr && (M_Tnew == '0);

  assign Fwd_D_RS_Sel = (D_A1 == '0) ? FROM_RF :
    fwd_pick(D_A1 == E_A3 && e_fwd_ok, D_A1 == M_A3 && m_fwd_ok, D_A1 == W_A3 && W_RFWr);
  assign Fwd_D_RT_Sel = (D_A2 == '0) ? FROM_RF :
    fwd_pick(D_A2 == E_A3 && e_fwd_ok, D_A2 == M_A3 && m_fwd_ok, D_A2 == W_A3 && W_RFWr);
  assign Fwd_E_A_Sel = (E_A1 == '0) ? FROM_RF :
    fwd_pick(1'b0, E_A1 == M_A3 && m_fwd_ok, E_A1 == W_A3 && W_RFWr);
  assign Fwd_E_B_Sel = (E_A2 == '0) ? FROM_RF :
    fwd_pick(1'b0, E_A2 == M_A3 && m_fwd_ok, E_A2 == W_A3 && W_RFWr);
  assign Fwd_M_WD_Sel = (M_A2 == '0) ? FROM_RF :
    fwd_pick(1'b0, 1'b0, M_A2 == W_A3 && W_RFWr);

  // Data stall: the consumer needs the value sooner than the producer has it.
  logic stall_rs_e, stall_rs_m, stall_rt_e, stall_rt_m, stall_data;
  assign stall_rs_e = (D_A1 != '0) && (D_A1 == E_A3) && E_RFWr && (T_use_RS < E_Tnew);
  assign stall_rs_m = (D_A1 != '0) && (D_A1 == M_A3) && M_RFWr && (T_use_RS < M_Tnew);
  assign stall_rt_e = (D_A2 != '0) && (D_A2 == E_A3) && E_RFWr && (T_use_RT < E_Tnew);
  assign stall_rt_m = (D_A2 != '0) && (D_A2 == M_A3) && M_RFWr && (T_use_RT < M_Tnew);
  assign stall_data = stall_rs_e | stall_rs_m | stall_rt_e | stall_rt_m;

  // MDU: the starting op counts as busy in its own cycle, before the
  // countdown has loaded.
  logic mdu_start_ok, stall_mdu;

  mdu_busy_timer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu_busy_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (E_MDU_start),
    .is_div   (E_MDU_is_div),
    .flush    (flush),
    .busy     (MDU_busy),
    .start_ok (mdu_start_ok)
  );

  assign stall_mdu = D_MDU_related & (mdu_start_ok | MDU_busy);

  // eret reads EPC in D; hold it while an older mtc0 to EPC is in flight.
  logic stall_eret;
  assign stall_eret = D_eret & ((E_MTC0 && (E_A3 == REG_AW'(EPC_ADDR))) ||
                                (M_MTC0 && (M_A3 == REG_AW'(EPC_ADDR))));

  assign Stall = stall_data | stall_mdu | stall_eret;

  logic e_bubble_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_bubble_reg <= 1'b0;
    else        e_bubble_reg <= Stall;
  end
  assign E_bubble = e_bubble_reg;

`ifdef HAZARD_PERF_CNT_EN
  // Index 0: data, 1: mdu, 2: eret. Causes count independently.
  logic [2:0]       perf_cause;
  logic [CNT_W-1:0] perf_cnt [3];
  assign perf_cause = {stall_eret, stall_mdu, stall_data};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               cnt_reg <= '0;
        else if (perf_cause[gi] && cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
      end
      assign perf_cnt[gi] = cnt_reg;
    end
  endgenerate

  assign perf_stall_data = perf_cnt[0];
  assign perf_stall_mdu  = perf_cnt[1];
  assign perf_stall_eret = perf_cnt[2];
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [1:0] T_use_RS, T_use_RT, E_Tnew, M_Tnew;
  logic [4:0] D_A1, D_A2, E_A1, E_A2, E_A3, M_A2, M_A3, W_A3;
  logic       E_RFWr, M_RFWr, W_RFWr;
  logic       D_MDU_related, D_eret, E_MTC0, M_MTC0;
  logic       E_MDU_start, E_MDU_is_div;
  logic       Stall, E_bubble, MDU_busy;
  logic [1:0] Fwd_D_RS_Sel, Fwd_D_RT_Sel, Fwd_E_A_Sel, Fwd_E_B_Sel, Fwd_M_WD_Sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_data, perf_stall_mdu, perf_stall_eret;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .T_use_RS      (T_use_RS),
    .T_use_RT      (T_use_RT),
    .E_Tnew        (E_Tnew),
    .M_Tnew        (M_Tnew),
    .D_A1          (D_A1),
    .D_A2          (D_A2),
    .E_A1          (E_A1),
    .E_A2          (E_A2),
    .E_A3          (E_A3),
    .M_A2          (M_A2),
    .M_A3          (M_A3),
    .W_A3          (W_A3),
    .E_RFWr        (E_RFWr),
    .M_RFWr        (M_RFWr),
    .W_RFWr        (W_RFWr),
    .D_MDU_related (D_MDU_related),
    .D_eret        (D_eret),
    .E_MTC0        (E_MTC0),
    .M_MTC0        (M_MTC0),
    .E_MDU_start   (E_MDU_start),
    .E_MDU_is_div  (E_MDU_is_div),
    .Stall         (Stall),
    .E_bubble      (E_bubble),
    .MDU_busy      (MDU_busy),
    .Fwd_D_RS_Sel  (Fwd_D_RS_Sel),
    .Fwd_D_RT_Sel  (Fwd_D_RT_Sel),
    .Fwd_E_A_Sel   (Fwd_E_A_Sel),
    .Fwd_E_B_Sel   (Fwd_E_B_Sel),
    .Fwd_M_WD_Sel  (Fwd_M_WD_Sel)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_data (perf_stall_data),
    .perf_stall_mdu  (perf_stall_mdu),
    .perf_stall_eret (perf_stall_eret)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic clear_inputs();
    flush = 0; T_use_RS = 0; T_use_RT = 0; E_Tnew = 0; M_Tnew = 0;
    D_A1 = 0; D_A2 = 0; E_A1 = 0; E_A2 = 0; E_A3 = 0; M_A2 = 0; M_A3 = 0; W_A3 = 0;
    E_RFWr = 0; M_RFWr = 0; W_RFWr = 0;
    D_MDU_related = 0; D_eret = 0; E_MTC0 = 0; M_MTC0 = 0;
    E_MDU_start = 0; E_MDU_is_div = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;

    // Reset state
    @(negedge clk);
    expect_v("rst_busy", 0); expect_v("rst_bubble", 0); expect_v("rst_stall", 0);
    expect_v("rst_rs_sel", 0); expect_v("rst_mwd_sel", 0);
    check(MDU_busy); check(E_bubble); check(Stall); check(Fwd_D_RS_Sel); check(Fwd_M_WD_Sel);
    rst_n = 1;

    // RAW through ALU: producer not ready -> stall, then bubble in E
    next_cycle();
    E_A3 = 8; E_RFWr = 1; E_Tnew = 1; D_A1 = 8; T_use_RS = 0;
    expect_v("raw_stall", 1); expect_v("raw_rs_sel", 0);
    @(negedge clk); check(Stall); check(Fwd_D_RS_Sel);
    next_cycle();
    E_Tnew = 0;
    expect_v("raw_bubble", 1); expect_v("raw_fwd_stall", 0); expect_v("raw_fwd_rs_sel", 1);
    @(negedge clk); check(E_bubble); check(Stall); check(Fwd_D_RS_Sel);
    next_cycle();
    expect_v("raw_bubble_clear", 0);
    @(negedge clk); check(E_bubble);

    // Tuse vs Tnew boundaries
    next_cycle();
    E_Tnew = 1; T_use_RS = 1;
    expect_v("tuse_eq_tnew", 0);
    @(negedge clk); check(Stall);
    next_cycle();
    E_Tnew = 3; T_use_RS = 2;
    expect_v("tuse_lt_tnew", 1);
    @(negedge clk); check(Stall);
    next_cycle();
    E_Tnew = 2; T_use_RS = 3;
    expect_v("tuse_gt_tnew", 0);
    @(negedge clk); check(Stall);
    next_cycle();
    E_A3 = 0; D_A1 = 0; E_Tnew = 3; T_use_RS = 0;
    expect_v("zero_no_stall", 0);
    @(negedge clk); check(Stall);

    // Priority E > M > W and zero register
    next_cycle();
    clear_inputs();
    D_A2 = 9; E_A1 = 9; E_A2 = 9; M_A2 = 9;
    E_A3 = 9; M_A3 = 9; W_A3 = 9; E_RFWr = 1; M_RFWr = 1; W_RFWr = 1;
    expect_v("prio_rt_e", 1); expect_v("prio_ea_m", 2); expect_v("prio_eb_m", 2);
    expect_v("prio_mwd_w", 3); expect_v("prio_stall", 0);
    @(negedge clk);
    check(Fwd_D_RT_Sel); check(Fwd_E_A_Sel); check(Fwd_E_B_Sel); check(Fwd_M_WD_Sel); check(Stall);
    next_cycle();
    E_RFWr = 0;
    expect_v("prio_rt_m", 2);
    @(negedge clk); check(Fwd_D_RT_Sel);
    next_cycle();
    M_Tnew = 1;
    expect_v("prio_rt_w", 3); expect_v("prio_ea_w", 3); expect_v("m_data_stall", 1);
    @(negedge clk); check(Fwd_D_RT_Sel); check(Fwd_E_A_Sel); check(Stall);
    next_cycle();
    M_Tnew = 0; E_RFWr = 1;
    D_A2 = 0; E_A1 = 0; M_A2 = 0; E_A3 = 0; M_A3 = 0; W_A3 = 0;
    expect_v("zero_rt_sel", 0); expect_v("zero_ea_sel", 0); expect_v("zero_mwd_sel", 0);
    @(negedge clk); check(Fwd_D_RT_Sel); check(Fwd_E_A_Sel); check(Fwd_M_WD_Sel);

    // Multiply: stall in t..t+5, busy in t+1..t+5
    next_cycle();
    clear_inputs();
    E_MDU_start = 1; D_MDU_related = 1;
    expect_v("mul_start_stall", 1); expect_v("mul_start_busy", 0);
    @(negedge clk); check(Stall); check(MDU_busy);
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      E_MDU_start = 0;
      expect_v($sformatf("mul_busy_%0d", i), 1); expect_v($sformatf("mul_stall_%0d", i), 1);
      @(negedge clk); check(MDU_busy); check(Stall);
    end
    next_cycle();
    expect_v("mul_done_busy", 0); expect_v("mul_done_stall", 0);
    @(negedge clk); check(MDU_busy); check(Stall);

    // Divide: 10 busy cycles
    next_cycle();
    D_MDU_related = 0; E_MDU_start = 1; E_MDU_is_div = 1;
    @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      E_MDU_start = 0; E_MDU_is_div = 0;
      expect_v($sformatf("div_busy_%0d", i), 1);
      @(negedge clk); check(MDU_busy);
    end
    next_cycle();
    expect_v("div_done_busy", 0);
    @(negedge clk); check(MDU_busy);

    // Flushed start is dropped
    next_cycle();
    E_MDU_start = 1; flush = 1; D_MDU_related = 1;
    expect_v("flush_start_stall", 0);
    @(negedge clk); check(Stall);
    next_cycle();
    E_MDU_start = 0; flush = 0;
    expect_v("flush_busy", 0); expect_v("flush_stall", 0);
    @(negedge clk); check(MDU_busy); check(Stall);

    // eret / EPC
    next_cycle();
    clear_inputs();
    D_eret = 1; M_MTC0 = 1; M_A3 = 14;
    expect_v("eret_m_epc", 1);
    @(negedge clk); check(Stall);
    next_cycle();
    M_A3 = 12;
    expect_v("eret_m_other", 0);
    @(negedge clk); check(Stall);
    next_cycle();
    M_MTC0 = 0; E_MTC0 = 1; E_A3 = 14;
    expect_v("eret_e_epc", 1);
    @(negedge clk); check(Stall);

    // Reset in the middle of a divide (count 4)
    next_cycle();
    clear_inputs();
    E_MDU_start = 1; E_MDU_is_div = 1; D_MDU_related = 1;
    for (int i = 1; i <= 7; i++) begin
      next_cycle();
      E_MDU_start = 0; E_MDU_is_div = 0;
    end
    expect_v("pre_rst_busy", 1); expect_v("pre_rst_bubble", 1);
    check(MDU_busy); check(E_bubble);
    rst_n = 0;
    #1;
    expect_v("rst_mid_busy", 0); expect_v("rst_mid_bubble", 0);
    check(MDU_busy); check(E_bubble);
`ifdef HAZARD_PERF_CNT_EN
    expect_v("perf_data_rst", 0); expect_v("perf_mdu_rst", 0); expect_v("perf_eret_rst", 0);
    check(perf_stall_data); check(perf_stall_mdu); check(perf_stall_eret);
`endif
    @(negedge clk);
    rst_n = 1;
    next_cycle();
    expect_v("post_rst_stall", 0); expect_v("post_rst_busy", 0);
    @(negedge clk); check(Stall); check(MDU_busy);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational hazard controller of the 5-stage MIPS pipeline (F/D/E/M/W).
- Owns the MDU busy timing internally: a latency countdown replaces the external busy input, with separate mult and div latencies.
- Generates D/E/M forwarding selects and the D-stage stall, plus an E-stage bubble-insert strobe.
- Sits beside the pipeline registers; takes register addresses, Tnew/Tuse and write enables from the stage decoders.

Parameters:
- REG_AW, 5, register-file address width
- TNEW_W, 2, width of every Tnew/Tuse field
- MUL_LAT, 5, busy cycles after a mult/multu start
- DIV_LAT, 10, busy cycles after a div/divu start
- EPC_ADDR, 14, CP0 register number of EPC (eret hazard target)
- CNT_W, 32, perf-counter width (used only with the optional feature)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  exception/interrupt flush this cycle; cancels the E-stage MDU start
- T_use_RS, T_use_RT  in  TNEW_W  D-stage use times
- E_Tnew, M_Tnew  in  TNEW_W  producer ready times
- D_A1, D_A2, E_A1, E_A2, E_A3, M_A2, M_A3, W_A3  in  REG_AW  stage register addresses
- E_RFWr, M_RFWr, W_RFWr  in  1  stage register-write enables
- D_MDU_related, D_eret  in  1  D-stage instruction class
- E_MTC0, M_MTC0  in  1  mtc0 in stage; the CP0 target is carried in E_A3/M_A3
- E_MDU_start, E_MDU_is_div  in  1  MDU operation issued from E
- Stall  out  1  freeze PC and F/D; D/E register inserts a bubble
- E_bubble  out  1  registered copy of Stall (E holds a bubble this cycle)
- MDU_busy  out  1  countdown non-zero
- Fwd_D_RS_Sel, Fwd_D_RT_Sel, Fwd_E_A_Sel, Fwd_E_B_Sel, Fwd_M_WD_Sel  out  2  forward selects

Behaviour:
- Reset (async, rst_n=0): mdu_cnt=0, MDU_busy=0, E_bubble=0. Combinational outputs follow their inputs.
- Forward encoding:
  - FROM_RF=0, FROM_E=1, FROM_M=2, FROM_W=3.
  - Priority E>M>W.
  - A source is eligible when its address matches the consumer's, its RFWr=1 and its Tnew==0. W has no Tnew qualifier.
  - Address 0 always selects FROM_RF.
  - D consumers see E/M/W; E consumers see M/W; M_WD sees W only.
- Data stall: raised for a source with addr!=0, addr==E_A3 (or M_A3), RFWr=1 and T_use < Tnew. Compare unsigned, full TNEW_W width.
- MDU countdown:
  - A start is accepted when E_MDU_start=1 and flush=0. It loads mdu_cnt with DIV_LAT if E_MDU_is_div=1, else MUL_LAT.
  - Otherwise mdu_cnt decrements while non-zero and holds at 0.
  - MDU_busy = (mdu_cnt != 0).
  - A start with flush=1 is dropped; the counter keeps its current value.
  - A start while MDU_busy=1 is illegal (D was stalled). Debug builds assert on it; the counter reloads anyway.
- stall_mdu = D_MDU_related & (accepted start | MDU_busy).
- stall_eret = D_eret & ((E_MTC0 & E_A3==EPC_ADDR) | (M_MTC0 & M_A3==EPC_ADDR)).
- Stall = OR of all data stalls, stall_mdu and stall_eret.
- E_bubble is registered Stall, cleared on reset.
- Latency:
  - Forwarding and Stall: 0 cycles.
  - MDU_busy rises the cycle after an accepted start and stays high exactly LAT cycles.
- Reset mid-operation: the counter clears immediately; there is no residual stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_data, perf_stall_mdu and perf_stall_eret (CNT_W each).
  - Each counter increments once per cycle its cause is active. Several causes in one cycle each increment.
  - Counters saturate at all-ones and clear on reset.
- Undefined: no counters, no ports, no logic.

Decomposition:
- Shared package hazard_pkg holds the FROM_RF/FROM_E/FROM_M/FROM_W codes and the default EPC_ADDR.
- One natural sub-module: mdu_busy_timer (countdown, flush gating, MDU_busy).

Test Plan:
- RAW through ALU: E_A3=8, E_RFWr=1, E_Tnew=1, D_A1=8, T_use_RS=0 -> Stall=1, then E_bubble=1 next cycle. Same inputs with E_Tnew=0 -> Stall=0, Fwd_D_RS_Sel=1.
- Priority and zero register: D_A2=9 matching E (Tnew 0), M (Tnew 0) and W -> Fwd_D_RT_Sel=1. With D_A2=0 and all matches set -> 0.
- Multiply latency: start with is_div=0 at cycle t -> MDU_busy=1 for cycles t+1..t+5. D_MDU_related=1 -> Stall=1 in cycles t..t+5 and 0 at t+6. A div start -> 10 busy cycles.
- Flush on start: E_MDU_start=1 with flush=1 -> MDU_busy stays 0 and D_MDU_related causes no stall.
- eret/EPC: M_MTC0=1, M_A3=14, D_eret=1 -> Stall=1. With M_A3=12 -> Stall=0.
- Reset mid-div: rst_n low at count 4 -> MDU_busy=0 at once. After release, D_MDU_related=1 -> Stall=0. With HAZARD_PERF_CNT_EN, all counters read 0.
